sc2bin_v2: RTL and testbench

//  Windowed stochastic-to-binary converter for split-unipolar streams, LANES bits/stream/cycle.

---
 rtl/sc2bin_v2_if.sv | 24 ++
 rtl/sc2bin_v2.sv | 176 +++++++++++++++++
 tb/tb_sc2bin_v2.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sc2bin_v2_if.sv
// Output handshake bundle for sc2bin_v2.
// The master drives the result and the slave drives out_ready.
interface sc2bin_v2_if #(
  parameter int BITWIDTH = 8
);
  logic                out_valid;
  logic                out_ready;
  logic                sat;
  logic [BITWIDTH-1:0] bin_out;

  modport master (
    output out_valid,
    output bin_out,
    output sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  bin_out,
    input  sat,
    output out_ready
  );
endinterface

// File: rtl/sc2bin_v2.sv
// Windowed split-unipolar stochastic-to-binary converter.
// It computes pos-neg over a sample window, then applies ReLU, a shift and saturation.
module sc2bin_v2 #(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 2,
  parameter int LEN_W    = 10,
  parameter int MAX_SHFT = 4,
  localparam int CNT_W   = LEN_W + $clog2(LANES + 1),
  localparam int SH_W    = $clog2(MAX_SHFT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             start,
  input  logic [LEN_W-1:0] win_len,
  input  logic             relu_en,
  input  logic [SH_W-1:0]  shft_amt,
  input  logic             sc_valid,
  input  logic [LANES-1:0] sc_pos,
  input  logic [LANES-1:0] sc_neg,
  output logic             busy,
  sc2bin_v2_if.master      out_if
);

  localparam int D_W = CNT_W + 1;
  localparam int S_W = D_W + MAX_SHFT;

  localparam logic signed [S_W-1:0] UMAX =
    S_W'((1 << BITWIDTH) - 1);
  localparam logic signed [S_W-1:0] SMAX =
    S_W'((1 << (BITWIDTH - 1)) - 1);
  localparam logic signed [S_W-1:0] SMIN =
    S_W'(-(1 << (BITWIDTH - 1)));
  localparam logic [SH_W-1:0] SH_LIM = SH_W'(MAX_SHFT);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    CONV,
    HOLD
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]    pos_cnt;
  logic [CNT_W-1:0]    neg_cnt;
  logic [LEN_W-1:0]    remaining;
  logic                relu_q;
  logic [SH_W-1:0]     shft_q;
  logic [BITWIDTH-1:0] bin_q;
  logic                sat_q;
  logic                vld_q;

  logic signed [D_W-1:0] d;
  logic signed [D_W-1:0] v;
  logic signed [S_W-1:0] sx;
  logic signed [S_W-1:0] s;
  logic [BITWIDTH-1:0]   res;
  logic                  res_sat;

  function automatic logic [CNT_W-1:0] popcnt(
    input logic [LANES-1:0] b
  );
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      acc = acc + CNT_W'(b[i]);
    end
    return acc;
  endfunction

  assign busy             = (state != IDLE);
  assign out_if.out_valid = vld_q;
  assign out_if.bin_out   = bin_q;
  assign out_if.sat       = sat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start)
            state_nx = (win_len != '0) ? ACCUM : CONV;
        end
        ACCUM: begin
          if (sc_valid && remaining == LEN_W'(1))
            state_nx = CONV;
        end
        CONV: state_nx = HOLD;
        HOLD: begin
          if (out_if.out_ready) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Shift at full width so saturation sees the true magnitude.
  always_comb begin
    d  = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    v  = (relu_q && d < 0) ? '0 : d;
    sx = {{MAX_SHFT{v[D_W-1]}}, v};
    s  = sx <<< shft_q;
    res     = s[BITWIDTH-1:0];
    res_sat = 1'b0;
    if (relu_q) begin
      if (s > UMAX) begin
        res     = '1;
        res_sat = 1'b1;
      end
    end else if (s > SMAX) begin
      res     = SMAX[BITWIDTH-1:0];
      res_sat = 1'b1;
    end else if (s < SMIN) begin
      res     = SMIN[BITWIDTH-1:0];
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_cnt   <= '0;
      neg_cnt   <= '0;
      remaining <= '0;
      relu_q    <= 1'b0;
      shft_q    <= '0;
      bin_q     <= '0;
      sat_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else if (clr) begin
      pos_cnt   <= '0;
      neg_cnt   <= '0;
      remaining <= '0;
      bin_q     <= '0;
      sat_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pos_cnt   <= '0;
            neg_cnt   <= '0;
            remaining <= win_len;
            relu_q    <= relu_en;
            shft_q    <= (shft_amt > SH_LIM) ? SH_LIM : shft_amt;
          end
        end
        ACCUM: begin
          if (sc_valid) begin
            pos_cnt   <= pos_cnt + popcnt(sc_pos);
            neg_cnt   <= neg_cnt + popcnt(sc_neg);
            remaining <= remaining - LEN_W'(1);
          end
        end
        CONV: begin
          bin_q <= res;
          sat_q <= res_sat;
          vld_q <= 1'b1;
        end
        HOLD: begin
          if (out_if.out_ready) vld_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc2bin_v2.sv
// Directed self-checking bench for sc2bin_v2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sc2bin_v2;

  logic       clk;
  logic       reset_n;
  logic       clr;
  logic       start;
  logic [9:0] win_len;
  logic       relu_en;
  logic [2:0] shft_amt;
  logic       sc_valid;
  logic [1:0] sc_pos;
  logic [1:0] sc_neg;
  logic       busy;

  int total;
  int passed;

  sc2bin_v2_if #(.BITWIDTH(8)) oif ();

  sc2bin_v2 #(
    .BITWIDTH(8),
    .LANES(2),
    .LEN_W(10),
    .MAX_SHFT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clr(clr),
    .start(start),
    .win_len(win_len),
    .relu_en(relu_en),
    .shft_amt(shft_amt),
    .sc_valid(sc_valid),
    .sc_pos(sc_pos),
    .sc_neg(sc_neg),
    .busy(busy),
    .out_if(oif.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] len,
                          input logic rl,
                          input logic [2:0] sh);
    start    = 1'b1;
    win_len  = len;
    relu_en  = rl;
    shft_amt = sh;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input int n,
                      input logic [1:0] p,
                      input logic [1:0] q);
    sc_valid = 1'b1;
    sc_pos   = p;
    sc_neg   = q;
    repeat (n) step();
    sc_valid = 1'b0;
    sc_pos   = '0;
    sc_neg   = '0;
  endtask

  task automatic result(input string tag,
                        input logic [7:0] b,
                        input logic s);
    chk({tag, "_conv_nv"}, 32'(oif.out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(oif.out_valid), 32'd1);
    chk({tag, "_bin"}, 32'(oif.bin_out), 32'(b));
    chk({tag, "_sat"}, 32'(oif.sat), 32'(s));
  endtask

  task automatic accept(input string tag);
    oif.out_ready = 1'b1;
    step();
    oif.out_ready = 1'b0;
    chk({tag, "_acc_nv"}, 32'(oif.out_valid), 32'd0);
    chk({tag, "_acc_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [5:0] pat;
    total         = 0;
    passed        = 0;
    reset_n       = 1'b0;
    clr           = 1'b0;
    start         = 1'b0;
    win_len       = '0;
    relu_en       = 1'b0;
    shft_amt      = '0;
    sc_valid      = 1'b0;
    sc_pos        = '0;
    sc_neg        = '0;
    oif.out_ready = 1'b0;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(oif.out_valid), 32'd0);
    chk("rst_bin", 32'(oif.bin_out), 32'd0);
    chk("rst_sat", 32'(oif.sat), 32'd0);
    #10 reset_n = 1'b1;
    step();

    // d = 8 - 4 = 4, shifted by 2 gives 16
    do_start(10'd4, 1'b1, 3'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    feed(4, 2'b11, 2'b01);
    result("t1", 8'd16, 1'b0);
    accept("t1");

    do_start(10'd2, 1'b1, 3'd0);
    feed(2, 2'b01, 2'b11);
    result("t2r", 8'h00, 1'b0);
    accept("t2r");
    do_start(10'd2, 1'b0, 3'd0);
    feed(2, 2'b01, 2'b11);
    result("t2s", 8'hFE, 1'b0);
    accept("t2s");

    do_start(10'd200, 1'b1, 3'd0);
    feed(200, 2'b11, 2'b00);
    result("t3r", 8'hFF, 1'b1);
    accept("t3r");
    do_start(10'd200, 1'b0, 3'd0);
    feed(200, 2'b11, 2'b00);
    result("t3s", 8'h7F, 1'b1);
    accept("t3s");

    // d = -200 clips to -128 when signed and to 0 under ReLU
    do_start(10'd100, 1'b0, 3'd0);
    feed(100, 2'b00, 2'b11);
    result("neg_s", 8'h80, 1'b1);
    accept("neg_s");
    do_start(10'd100, 1'b1, 3'd0);
    feed(100, 2'b00, 2'b11);
    result("neg_r", 8'h00, 1'b0);
    accept("neg_r");

    // shift 7 clamps to 4: 1 << 4 = 16
    do_start(10'd1, 1'b0, 3'd7);
    feed(1, 2'b01, 2'b00);
    result("clamp", 8'd16, 1'b0);
    accept("clamp");

    do_start(10'd3, 1'b1, 3'd0);
    pat    = 6'b101001;
    sc_pos = 2'b10;
    for (int i = 0; i < 6; i++) begin
      sc_valid = pat[i];
      step();
      if (i == 4)
        chk("t4_busy5", 32'(busy), 32'd1);
    end
    sc_valid = 1'b0;
    sc_pos   = '0;
    result("t4", 8'd3, 1'b0);

    for (int i = 0; i < 5; i++) begin
      start   = (i == 2);
      win_len = 10'd5;
      step();
      chk("hold_valid", 32'(oif.out_valid), 32'd1);
      chk("hold_bin", 32'(oif.bin_out), 32'd3);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    start = 1'b1;
    accept("hs");
    start = 1'b0;
    step();
    chk("hs_start_ign", 32'(busy), 32'd0);
    chk("hs_bin_keep", 32'(oif.bin_out), 32'd3);

    do_start(10'd10, 1'b1, 3'd0);
    feed(3, 2'b11, 2'b00);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_bin", 32'(oif.bin_out), 32'd0);
    chk("clr_valid", 32'(oif.out_valid), 32'd0);
    clr   = 1'b1;
    start = 1'b1;
    step();
    clr   = 1'b0;
    start = 1'b0;
    chk("clr_beats_start", 32'(busy), 32'd0);

    do_start(10'd2, 1'b0, 3'd0);
    feed(2, 2'b01, 2'b00);
    result("post_clr", 8'd2, 1'b0);
    accept("post_clr");

    do_start(10'd10, 1'b1, 3'd0);
    feed(3, 2'b11, 2'b00);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_bin", 32'(oif.bin_out), 32'd0);
    chk("arst_valid", 32'(oif.out_valid), 32'd0);
    #2 reset_n = 1'b1;
    step();
    chk("arst_idle", 32'(busy), 32'd0);

    // zero-length window: result two edges after start
    do_start(10'd0, 1'b1, 3'd3);
    chk("w0_busy", 32'(busy), 32'd1);
    result("w0", 8'd0, 1'b0);
    accept("w0");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
